// File: rtl/adder_seq_chunked_pkg.sv
// Shared types and helpers for the sliced sequential adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } adder_state_t;

  // Number of W-bit slices needed to cover n bits (ceil(n/w)).
  function automatic int nchunks(int n, int w);
    return (n + w - 1) / w;
  endfunction

endpackage

// File: rtl/adder_seq_chunked_if.sv
// Start/done handshake and operand/result bus of the sliced adder.
// ADDER_SUB_EN adds the SUB request bit and the OVF result bit.
interface adder_seq_chunked_if #(
  parameter int N = 8
);

  logic         START;
  logic [N-1:0] P;
  logic [N-1:0] Q;
  logic         CIN;
  logic [N-1:0] SUM;
  logic         COUT;
  logic         BUSY;
  logic         DONE;
`ifdef ADDER_SUB_EN
  logic         SUB;
  logic         OVF;

  modport master (output START, P, Q, CIN, SUB, input SUM, COUT, BUSY, DONE, OVF);
  modport slave  (input START, P, Q, CIN, SUB, output SUM, COUT, BUSY, DONE, OVF);
`else
  modport master (output START, P, Q, CIN, input SUM, COUT, BUSY, DONE);
  modport slave  (input START, P, Q, CIN, output SUM, COUT, BUSY, DONE);
`endif

endinterface

// File: rtl/adder_seq_chunked_slice.sv
// Plain combinational N-bit adder with carry in/out; used as the per-cycle slice adder.
module adder_N #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/adder_seq_chunked.sv
// Multi-cycle N-bit adder: P+Q+CIN computed W bits per clock, LSB slice first,
// with the carry held in a register between slices.
// Optional macro ADDER_SUB_EN: adds SUB (P-Q) and the signed overflow flag OVF.
module adder_seq_chunked
  import adder_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic CLK,
  input  logic N_RESET,
  adder_seq_chunked_if.slave bus
);

  localparam int NCH = nchunks(N, W);
  localparam int NP  = NCH * W;       // operand width including last-slice padding
  localparam int CW  = $clog2(NCH) + 1;
  localparam int R   = (N - 1) % W;   // position of operand bit N-1 inside the last slice

  adder_state_t  state;
  logic [N-1:0]  p_q;
  logic [N-1:0]  q_q;
  logic [N-1:0]  sum_q;
  logic          carry_q;
  logic          cout_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] idx;

  logic [NP-1:0] p_pad;
  logic [NP-1:0] q_pad;
  logic [W-1:0]  slice_a;
  logic [W-1:0]  slice_b;
  logic [W-1:0]  slice_sum;
  logic          slice_co;
  logic          msb_co;
  logic          last;
  logic [N-1:0]  sum_upd;

  // Pad bits above N-1 are zero, so the last slice never adds stray operand bits.
  assign p_pad   = NP'(p_q);
  assign q_pad   = NP'(q_q);
  assign slice_a = W'(p_pad >> (int'(idx) * W));
  assign slice_b = W'(q_pad >> (int'(idx) * W));
  assign last    = (idx == CW'(NCH - 1));

  adder_N #(.N(W)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_co)
  );

  // Carry out of bit N-1: with zero pad operands it lands in the next slice bit,
  // unless bit N-1 is already the slice MSB.
  generate
    if (R == W - 1) begin : g_tap_co
      assign msb_co = slice_co;
    end else begin : g_tap_pad
      assign msb_co = slice_sum[R + 1];
    end
  endgenerate

`ifdef ADDER_SUB_EN
  logic msb_ci;
  logic ovf_q;

  // Carry into bit N-1 recovered from its sum bit and operand bits.
  assign msb_ci = slice_sum[R] ^ slice_a[R] ^ slice_b[R];
`endif

  // Merge the current slice result into its bit positions of the running sum.
  generate
    for (genvar b = 0; b < N; b++) begin : g_upd
      assign sum_upd[b] = (idx == CW'(b / W)) ? slice_sum[b % W] : sum_q[b];
    end
  endgenerate

  // Sequencer: accept operands, add one slice per edge, pulse DONE in FIN.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state   <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx     <= '0;
`ifdef ADDER_SUB_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge state and later defaults cannot race earlier reads.
      done_q <= 1'b0;
      unique case (state)
        IDLE, FIN: begin
          if (bus.START) begin
            p_q     <= bus.P;
`ifdef ADDER_SUB_EN
            q_q     <= bus.SUB ? ~bus.Q : bus.Q;
            carry_q <= bus.SUB ? 1'b1 : bus.CIN;
            ovf_q   <= 1'b0;
`else
            q_q     <= bus.Q;
            carry_q <= bus.CIN;
`endif
            sum_q   <= '0;
            cout_q  <= 1'b0;
            idx     <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end else begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        RUN: begin
          sum_q   <= sum_upd;
          carry_q <= slice_co;
          if (last) begin
            cout_q <= msb_co;
`ifdef ADDER_SUB_EN
            ovf_q  <= msb_ci ^ msb_co;
`endif
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FIN;
          end else begin
            idx <= idx + CW'(1);
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.SUM  = sum_q;
  assign bus.COUT = cout_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
`ifdef ADDER_SUB_EN
  assign bus.OVF  = ovf_q;
`endif

endmodule
